// File: rtl/bridge_pkg.sv
// Shared definitions for the ASCII register bridge (host and device sides).
// Holds the framing constants, the FSM state encoding and the hex/ASCII helpers.
package bridge_pkg;

  localparam logic [7:0] PREAMBLE = 8'h4D;
  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] LF       = 8'h0A;

  typedef logic [1:0] bridge_state_t;
  localparam bridge_state_t IDLE      = 2'd0;
  localparam bridge_state_t SEND      = 2'd1;
  localparam bridge_state_t WAIT_RESP = 2'd2;

  // Nibble to uppercase ASCII hex digit.
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h37 + {4'h0, n};
  endfunction

  // Uppercase hex digits only: '0'-'9', 'A'-'F'.
  function automatic logic is_hex(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) || ((c >= 8'h41) && (c <= 8'h46));
  endfunction

  // Only meaningful when is_hex(c) is true.
  function automatic logic [3:0] ascii_to_hex(input logic [7:0] c);
    logic [7:0] v;
    v = (c <= 8'h39) ? (c - 8'h30) : (c - 8'h37);
    return v[3:0];
  endfunction

endpackage

// File: rtl/bridge_resp_parser.sv
// Read-response parser: recognises 'M' D3 D2 D1 D0 CR LF and collects the data.
// Ports: clk, rst (async, active high), clear (sync restart), rx_data/rx_valid
// (byte stream), done/err (same-cycle completion flags, qualified by rx_valid),
// rdata (collected data, valid with done).
module bridge_resp_parser
  import bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        done,
  output logic        err,
  output logic [15:0] rdata
);

  logic [2:0]  p_q;
  logic [15:0] shift_q;

  // Completion flags are decoded from the current byte so the owner can
  // respond on the very next edge.
  always_comb begin
    done = 1'b0;
    err  = 1'b0;
    if (rx_valid && !clear) begin
      case (p_q)
        3'd0:                   ;
        3'd1, 3'd2, 3'd3, 3'd4: err = !is_hex(rx_data);
        3'd5:                   err = (rx_data != CR);
        3'd6: begin
          done = (rx_data == LF);
          err  = (rx_data != LF);
        end
        default:                err = 1'b1;
      endcase
    end
  end

  // Position and data shift register; bytes before the preamble are noise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q     <= '0;
      shift_q <= '0;
    end else if (clear) begin
      p_q     <= '0;
      shift_q <= '0;
    end else if (rx_valid) begin
      case (p_q)
        3'd0: if (rx_data == PREAMBLE) p_q <= 3'd1;
        3'd1, 3'd2, 3'd3, 3'd4: begin
          if (is_hex(rx_data)) begin
            shift_q <= {shift_q[11:0], ascii_to_hex(rx_data)};
            p_q     <= p_q + 3'd1;
          end
        end
        3'd5: if (rx_data == CR) p_q <= 3'd6;
        default: p_q <= '0;
      endcase
    end
  end

  assign rdata = shift_q;

endmodule

// File: rtl/bridge_host.sv
// Host side of the ASCII register bridge: serialises a parallel read/write
// request into "M AAAA [DDDD] CR LF" and parses the device's read response.
// Ports: clk, rst (async, active high); req_* (request handshake in);
// resp_* (1-cycle completion pulse out); tx_* (bytes to UART transmitter);
// rx_* (byte strobes from UART receiver).
module bridge_host
  import bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic        req_rw,
  input  logic        req_valid,
  output logic        req_ready,
  output logic [15:0] resp_rdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  localparam bit          TO_EN  = (TIMEOUT_CYCLES > 0);
  localparam int unsigned TW     = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  bridge_state_t state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [15:0]   addr_q, wdata_q;
  logic          rw_q;
  logic          accept;
  logic          rv_d, re_d;
  logic [15:0]   rd_d;
  logic [3:0]    last_idx;
  logic          p_clear, p_rx_valid, p_done, p_err;
  logic [15:0]   p_rdata;

  assign req_ready = (state_q == IDLE);
  assign tx_valid  = (state_q == SEND);
  assign last_idx  = rw_q ? 4'd10 : 4'd6;

  // Parser only sees bytes while a response is expected.
  assign p_clear    = (state_q != WAIT_RESP);
  assign p_rx_valid = rx_valid && (state_q == WAIT_RESP);

  bridge_resp_parser u_parser (
    .clk      (clk),
    .rst      (rst),
    .clear    (p_clear),
    .rx_data  (rx_data),
    .rx_valid (p_rx_valid),
    .done     (p_done),
    .err      (p_err),
    .rdata    (p_rdata)
  );

  // Next-state and completion logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    rv_d    = 1'b0;
    re_d    = 1'b0;
    rd_d    = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (idx_q == last_idx) begin
            idx_d = '0;
            if (rw_q) begin
              state_d = IDLE;
              rv_d    = 1'b1;
            end else begin
              state_d = WAIT_RESP;
              cnt_d   = '0;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      WAIT_RESP: begin
        if (TO_EN) cnt_d = cnt_q + TW'(1);
        // A completing LF beats a coincident timeout.
        if (p_done) begin
          state_d = IDLE;
          rv_d    = 1'b1;
          rd_d    = p_rdata;
        end else if (p_err || (TO_EN && (cnt_q == T_LAST))) begin
          state_d = IDLE;
          rv_d    = 1'b1;
          re_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers and registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rw_q       <= 1'b0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
    end else begin
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      resp_valid <= rv_d;
      resp_error <= re_d;
      resp_rdata <= rd_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rw_q    <= req_rw;
      end
    end
  end

  // Byte mux: byte index plus latched fields select the outgoing character.
  always_comb begin
    tx_data = 8'h00;
    if (state_q == SEND) begin
      case (idx_q)
        4'd0:    tx_data = PREAMBLE;
        4'd1:    tx_data = hex_to_ascii(addr_q[15:12]);
        4'd2:    tx_data = hex_to_ascii(addr_q[11:8]);
        4'd3:    tx_data = hex_to_ascii(addr_q[7:4]);
        4'd4:    tx_data = hex_to_ascii(addr_q[3:0]);
        4'd5:    tx_data = rw_q ? hex_to_ascii(wdata_q[15:12]) : CR;
        4'd6:    tx_data = rw_q ? hex_to_ascii(wdata_q[11:8]) : LF;
        4'd7:    tx_data = hex_to_ascii(wdata_q[7:4]);
        4'd8:    tx_data = hex_to_ascii(wdata_q[3:0]);
        4'd9:    tx_data = CR;
        4'd10:   tx_data = LF;
        default: tx_data = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_bridge_host.sv
module tb_bridge_host;

  localparam int unsigned TO = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req_addr, req_wdata;
  logic        req_rw, req_valid, req_ready;
  logic [15:0] resp_rdata;
  logic        resp_valid, resp_error;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;

  bridge_host #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rw(req_rw),
    .req_valid(req_valid), .req_ready(req_ready),
    .resp_rdata(resp_rdata), .resp_valid(resp_valid), .resp_error(resp_error),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic        tog;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [71:0] rx;
    logic [3:0]  rx_len;
    logic        exp_err;
    logic [15:0] exp_rdata;
  } vec_t;

  int compared = 0;
  int failed   = 0;
  int cyc      = 0;
  int resp_cnt = 0;
  int acc_cnt  = 0;
  int resp_cyc = 0;
  int acc_cyc  = 0;
  int hs_cyc   = 0;
  int rx_cyc   = 0;
  logic        last_err;
  logic [15:0] last_rd;
  logic        prev_rv   = 1'b0;
  logic        hold_pend = 1'b0;
  logic [7:0]  hold_data = 8'h00;
  logic        tog       = 1'b0;
  logic [7:0]  txq[$];
  logic [16:0] resp_q[$];
  int          resp_cq[$];
  int          acc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h41 + 8'(n) - 8'd10);
  endfunction

  function automatic vec_t mk(input logic rw, input logic tg, input logic [15:0] a,
                              input logic [15:0] d, input logic [71:0] rx,
                              input logic [3:0] n, input logic e, input logic [15:0] rd);
    vec_t v;
    v.rw = rw; v.tog = tg; v.addr = a; v.wdata = d; v.rx = rx; v.rx_len = n;
    v.exp_err = e; v.exp_rdata = rd;
    return v;
  endfunction

  // Cycle counter and negedge monitor of all DUT handshakes.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      hold_pend = 1'b0;
      prev_rv   = 1'b0;
    end else begin
      if (hold_pend) chk("tx_hold", 32'({tx_valid, tx_data}), 32'({1'b1, hold_data}));
      hold_pend = tx_valid && !tx_ready;
      hold_data = tx_data;
      if (resp_valid) begin
        chk("resp_req_ready", 32'(req_ready), 32'd1);
        chk("resp_pulse", 32'(prev_rv), 32'd0);
        resp_cnt++;
        last_err = resp_error;
        last_rd  = resp_rdata;
        resp_cyc = cyc;
        resp_q.push_back({resp_error, resp_rdata});
        resp_cq.push_back(cyc);
      end
      prev_rv = resp_valid;
      if (tx_valid && tx_ready) begin
        txq.push_back(tx_data);
        hs_cyc = cyc;
      end
      if (req_valid && req_ready) begin
        acc_cnt++;
        acc_cyc = cyc;
        acc_q.push_back(cyc);
      end
      if (rx_valid) rx_cyc = cyc;
    end
  end

  // tx_ready: held high, or toggled every cycle when tog is set.
  initial forever begin
    @(posedge clk);
    #1;
    tx_ready = tog ? ~tx_ready : 1'b1;
  end

  task automatic wait_acc(input int target, input int lim);
    int k = 0;
    while (acc_cnt < target && k < lim) begin @(negedge clk); #2; k++; end
    chk("wait_accept", 32'(acc_cnt >= target), 32'd1);
  endtask

  task automatic wait_tx(input int target, input int lim);
    int k = 0;
    while (txq.size() < target && k < lim) begin @(negedge clk); #2; k++; end
    chk("wait_tx_bytes", 32'(txq.size() >= target), 32'd1);
  endtask

  task automatic wait_resp(input int target, input int lim);
    int k = 0;
    while (resp_cnt < target && k < lim) begin @(negedge clk); #2; k++; end
    chk("wait_resp", 32'(resp_cnt >= target), 32'd1);
  endtask

  task automatic feed(input logic [71:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      rx_data  = s[8*(n-1-i) +: 8];
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic [7:0] e[11];
    int n, rb, ab;
    e[0] = 8'h4D;
    e[1] = hc(v.addr[15:12]); e[2] = hc(v.addr[11:8]);
    e[3] = hc(v.addr[7:4]);   e[4] = hc(v.addr[3:0]);
    if (v.rw) begin
      e[5] = hc(v.wdata[15:12]); e[6] = hc(v.wdata[11:8]);
      e[7] = hc(v.wdata[7:4]);   e[8] = hc(v.wdata[3:0]);
      e[9] = 8'h0D; e[10] = 8'h0A; n = 11;
    end else begin
      e[5] = 8'h0D; e[6] = 8'h0A; n = 7;
      for (int i = 7; i < 11; i++) e[i] = 8'h00;
    end
    txq.delete();
    rb  = resp_cnt;
    ab  = acc_cnt;
    tog = v.tog;
    @(posedge clk); #1;
    req_addr = v.addr; req_wdata = v.wdata; req_rw = v.rw; req_valid = 1'b1;
    wait_acc(ab + 1, 20);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_tx(n, 200);
    @(posedge clk); #1;
    tog = 1'b0;
    feed(v.rx, int'(v.rx_len));
    wait_resp(rb + 1, 100);
    repeat (4) @(posedge clk);
    #1;
    chk($sformatf("v%0d_tx_len", id), 32'(txq.size()), 32'(n));
    for (int i = 0; i < n; i++)
      chk($sformatf("v%0d_tx_byte%0d", id, i),
          (i < txq.size()) ? 32'(txq[i]) : 32'hFFFF_FFFF, 32'(e[i]));
    chk($sformatf("v%0d_resp_count", id), 32'(resp_cnt - rb), 32'd1);
    chk($sformatf("v%0d_resp_error", id), 32'(last_err), 32'(v.exp_err));
    chk($sformatf("v%0d_resp_rdata", id), 32'(last_rd), 32'(v.exp_rdata));
    if (v.rw && !v.tog)
      chk($sformatf("v%0d_write_latency", id), 32'(resp_cyc - acc_cyc), 32'd12);
    if (!v.rw && !v.exp_err)
      chk($sformatf("v%0d_lf_latency", id), 32'(resp_cyc - rx_cyc), 32'd1);
  endtask

  vec_t tab[9];
  logic [71:0] stray;
  logic [7:0]  rd_exp[7];
  int rb, ab;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_addr = '0; req_wdata = '0; req_rw = 1'b0; req_valid = 1'b0;
    rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b1;

    tab[0] = mk(1'b0, 1'b0, 16'h1234, 16'h0000, 72'("MBEEF\r\n"),   4'd7, 1'b0, 16'hBEEF);
    tab[1] = mk(1'b1, 1'b1, 16'h00A5, 16'hC0DE, 72'h0,              4'd0, 1'b0, 16'h0000);
    tab[2] = mk(1'b0, 1'b0, 16'h0001, 16'h0000, 72'("xyMG000\r\n"), 4'd9, 1'b1, 16'h0000);
    tab[3] = mk(1'b1, 1'b0, 16'hFFFF, 16'h0001, 72'h0,              4'd0, 1'b0, 16'h0000);
    tab[4] = mk(1'b0, 1'b1, 16'hABCD, 16'h0000, 72'("M0000\r\n"),   4'd7, 1'b0, 16'h0000);
    tab[5] = mk(1'b0, 1'b0, 16'h5555, 16'h0000, 72'("Mbeef\r\n"),   4'd7, 1'b1, 16'h0000);
    tab[6] = mk(1'b0, 1'b0, 16'h7777, 16'h0000, 72'("M1234\n\n"),   4'd7, 1'b1, 16'h0000);
    tab[7] = mk(1'b0, 1'b0, 16'h8888, 16'h0000, 72'("MA5A5\rX"),    4'd7, 1'b1, 16'h0000);
    tab[8] = mk(1'b0, 1'b0, 16'h0F0F, 16'h0000, 72'("M9A0F\r\n"),   4'd7, 1'b0, 16'h9A0F);

    #1;
    chk("reset_req_ready",  32'(req_ready),  32'd1);
    chk("reset_tx_valid",   32'(tx_valid),   32'd0);
    chk("reset_tx_data",    32'(tx_data),    32'd0);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_resp_error", 32'(resp_error), 32'd0);
    chk("reset_resp_rdata", 32'(resp_rdata), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(tab[i], i);

    // Timeout with no response, then a stray frame while idle.
    txq.delete(); rb = resp_cnt; ab = acc_cnt;
    @(posedge clk); #1;
    req_addr = 16'h0042; req_rw = 1'b0; req_valid = 1'b1;
    wait_acc(ab + 1, 20);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_tx(7, 50);
    wait_resp(rb + 1, 120);
    chk("to_latency", 32'(resp_cyc - (hs_cyc + 1)), 32'd50);
    chk("to_error", 32'(last_err), 32'd1);
    chk("to_rdata", 32'(last_rd), 32'd0);
    @(posedge clk); #1;
    stray = 72'("M0001\r\n");
    feed(stray, 7);
    repeat (5) @(posedge clk);
    #1;
    chk("to_stray_ignored", 32'(resp_cnt - rb), 32'd1);
    chk("to_stray_no_tx", 32'(txq.size()), 32'd7);

    // Reset in the middle of sending a read.
    txq.delete(); rb = resp_cnt; ab = acc_cnt;
    @(posedge clk); #1;
    req_addr = 16'h1111; req_rw = 1'b0; req_valid = 1'b1;
    wait_acc(ab + 1, 20);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_tx(4, 20);
    #1 rst = 1'b1;
    #1;
    chk("rst_tx_valid",  32'(tx_valid),  32'd0);
    chk("rst_tx_data",   32'(tx_data),   32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_no_resp", 32'(resp_cnt - rb), 32'd0);
    run_vec(mk(1'b0, 1'b0, 16'hFFFF, 16'h0000, 72'("M1234\r\n"), 4'd7, 1'b0, 16'h1234), 100);

    // Back-to-back: write then read with req_valid held high.
    txq.delete(); resp_q.delete(); resp_cq.delete(); acc_q.delete();
    rb = resp_cnt; ab = acc_cnt;
    @(posedge clk); #1;
    req_addr = 16'h1000; req_wdata = 16'h0055; req_rw = 1'b1; req_valid = 1'b1;
    wait_acc(ab + 1, 20);
    @(posedge clk); #1;
    req_addr = 16'h2000; req_rw = 1'b0;
    wait_acc(ab + 2, 60);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_tx(18, 100);
    @(posedge clk); #1;
    stray = 72'("M5A5A\r\n");
    feed(stray, 7);
    wait_resp(rb + 2, 100);
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_resp_count", 32'(resp_cnt - rb), 32'd2);
    chk("b2b_accept_in_resp_cycle",
        (acc_q.size() > 1 && resp_cq.size() > 0) ? 32'(acc_q[1] - resp_cq[0]) : 32'hFFFF_FFFF, 32'd0);
    chk("b2b_first_resp",  (resp_q.size() > 0) ? 32'(resp_q[0]) : 32'hFFFF_FFFF, 32'h0_0000);
    chk("b2b_second_resp", (resp_q.size() > 1) ? 32'(resp_q[1]) : 32'hFFFF_FFFF, 32'h0_5A5A);
    rd_exp[0] = 8'h4D; rd_exp[1] = 8'h32; rd_exp[2] = 8'h30; rd_exp[3] = 8'h30;
    rd_exp[4] = 8'h30; rd_exp[5] = 8'h0D; rd_exp[6] = 8'h0A;
    chk("b2b_tx_len", 32'(txq.size()), 32'd18);
    for (int i = 0; i < 7; i++)
      chk($sformatf("b2b_read_byte%0d", i),
          (11 + i < txq.size()) ? 32'(txq[11 + i]) : 32'hFFFF_FFFF, 32'(rd_exp[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
